banked_mem_ctrl: RTL
====================

// Module: banked_mem_ctrl
// PURPOSE
//  Parametrised single-port banked memory with a registered read pipeline,
//  reset-triggered hardware clear sweep, busy/valid handshakes and error
//  flagging. Replaces the fixed 4x1024x8 bank memory in the checker
//  environment. Sits behind the bus/checker driver as the device under test.
// PARAMETERS
//  DATA_W       8     data word width, bits
//  BANKS        4     number of banks (power of 2, >=2)
//  DEPTH        1024  words per bank (power of 2, >=4)
//  RD_LAT       2     read latency in clk cycles (1 or 2 only)
//  CLEAR_ON_RST 1     1: zero all words after reset; 0: contents kept
//  Derived: BW=$clog2(BANKS), DW=$clog2(DEPTH), AW=BW+DW
// PORTS
//  clk         in   1       clock; all state changes on rising edge
//  rst         in   1       synchronous reset, active-high
//  cen         in   1       chip enable, active-low; high = idle
//  rd          in   1       read request, sampled when cen=0
//  wr          in   1       write request, sampled when cen=0
//  address     in   AW      [AW-1:DW]=bank, [DW-1:0]=word in bank
//  din         in   DATA_W  write data
//  dout        out  DATA_W  read data, held until next valid read
//  dout_valid  out  1       1-cycle pulse, dout carries new read data
//  busy        out  1       clear sweep running; requests rejected
//  err         out  1       1-cycle pulse: rejected request
// BEHAVIOUR
//  Reset (rst=1 at edge): dout=0, dout_valid=0, err=0, read pipe flushed,
//   sweep_idx=0, busy=CLEAR_ON_RST. Memory array itself is not reset.
//  Clear sweep (CLEAR_ON_RST=1): on each edge with rst=0 and busy=1, word
//   sweep_idx of every bank is written 0, sweep_idx++. After index DEPTH-1
//   is cleared, busy=0 from the next cycle. Total: DEPTH cycles after the
//   first rst=0 edge. rst reasserted mid-sweep restarts from index 0.
//  Request decode (edge, rst=0):
//   cen=1                    -> no op, no err, outputs hold
//   cen=0, rd=0, wr=0        -> no op
//   cen=0, wr=1, rd=0, !busy -> mem[bank][word]<=din this edge
//   cen=0, rd=1, wr=0, !busy -> read issued; data on dout with
//    dout_valid=1 exactly RD_LAT cycles after issue edge
//   cen=0, rd=1, wr=1        -> neither performed, err=1 next cycle
//   cen=0, (rd|wr), busy=1   -> dropped, err=1 next cycle
//  Read pipeline: fully pipelined; back-to-back reads every cycle give
//   back-to-back dout_valid pulses, in order. Read data captured from the
//   array at the issue edge: a write to the same address in the next cycle
//   does not alter an in-flight read; a read issued after a write edge
//   returns the new data (no write->read bubble).
//  dout holds last valid data while dout_valid=0; never driven X.
//  err is registered, asserted 1 cycle after the offending edge, width 1
//   cycle per offending request (consecutive bad requests -> err stays 1).
//  rst mid-read: in-flight reads discarded, no dout_valid after reset.
//  Address wrap: none; every AW-bit address is legal and distinct.
// TESTING
//  1 Reset, DEPTH=16: rst 1 cycle -> busy=1 for exactly 16 cycles, then 0;
//    read any addr -> dout=0x00, dout_valid RD_LAT cycles later.
//  2 Write 0xA5 @0x3FF, 0x5A @0xC00, read both back-to-back -> 0xA5 then
//    0x5A on consecutive cycles, RD_LAT=2 and RD_LAT=1 builds.
//  3 rd=wr=1 @0x010 with din=0x77 -> err pulse, mem[0x010] unchanged,
//    no dout_valid; cen=1 with rd=1 -> no err, no dout_valid.
//  4 Request during sweep -> err=1, dropped; rst at sweep cycle 5 ->
//    sweep restarts, busy lasts DEPTH more cycles.
//  5 Read 0x020 then write 0x99 @0x020 next cycle -> old data returned;
//    following read -> 0x99. rst with read in flight -> no dout_valid.
//  6 CLEAR_ON_RST=0: busy=0 one cycle after rst; prior data preserved.

Source files
------------

// File: rtl/banked_mem_ctrl.sv
// -----------------------------------------------------------------------------
// banked_mem_ctrl
//   Single-port banked memory with a registered read pipeline, a hardware
//   clear sweep after reset, busy/valid handshakes and a rejected-request
//   error pulse.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active-high
//   cen         chip enable, active-low (high = idle)
//   rd, wr      read / write request, sampled while cen=0
//   address     {bank, word}; [AW-1:DW] selects the bank, [DW-1:0] the word
//   din         write data
//   dout        read data, held until the next valid read
//   dout_valid  one-cycle pulse when dout carries new read data
//   busy        clear sweep running; requests are rejected
//   err         one-cycle pulse per rejected request
// -----------------------------------------------------------------------------
module banked_mem_ctrl #(
    parameter  int DATA_W       = 8,
    parameter  int BANKS        = 4,
    parameter  int DEPTH        = 1024,
    parameter  int RD_LAT       = 2,
    parameter  int CLEAR_ON_RST = 1,
    localparam int BW           = $clog2(BANKS),
    localparam int DW           = $clog2(DEPTH),
    localparam int AW           = BW + DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              rd,
    input  logic              wr,
    input  logic [AW-1:0]     address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DW-1:0]       r_sweep_idx;
    logic [DATA_W-1:0]   r_mem [BANKS][DEPTH];
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;
    logic                r_err;

    logic [BW-1:0]       w_bank;
    logic [DW-1:0]       w_word;
    logic                w_busy;
    logic                w_rd_ok;
    logic                w_wr_ok;
    logic                w_bad;
    logic                w_sweep_last;
    logic [DATA_W-1:0]   w_rd_data;

    // Request decode: accepted read/write strobes and the rejection condition.
    always_comb begin
        w_bank       = address[AW-1:DW];
        w_word       = address[DW-1:0];
        w_busy       = (r_state == ST_CLEAR);
        w_rd_ok      = !cen && rd && !wr && !w_busy;
        w_wr_ok      = !cen && wr && !rd && !w_busy;
        // rd+wr together is ambiguous; any request while sweeping is dropped.
        w_bad        = !cen && ((rd && wr) || ((rd || wr) && w_busy));
        w_sweep_last = (r_sweep_idx == DW'(DEPTH - 1));
        // Array read happens at the issue edge, so later writes cannot
        // disturb a read already in flight.
        w_rd_data    = r_mem[w_bank][w_word];
    end

    // Sweep FSM next-state: leave CLEAR once the last word index is written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (w_sweep_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_IDLE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Sweep FSM state and sweep index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RST_STATE;
            r_sweep_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_busy) begin
                r_sweep_idx <= r_sweep_idx + DW'(1);
            end
        end
    end

    // Storage array: clear sweep writes one word index in every bank per
    // cycle; otherwise accepted writes. The array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy) begin
                for (int b = 0; b < BANKS; b++) begin
                    r_mem[b][r_sweep_idx] <= '0;
                end
            end else if (w_wr_ok) begin
                r_mem[w_bank][w_word] <= din;
            end
        end
    end

    // Error pulse, registered one cycle after the offending edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Single-stage read: array word goes straight into dout.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_dout <= w_rd_data;
                    end
                end
            end
        end else begin : g_lat2
            logic              r_p_vld;
            logic [DATA_W-1:0] r_p_data;

            // Two-stage read: capture stage, then output stage; one read may
            // enter every cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p_vld      <= 1'b0;
                    r_p_data     <= '0;
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_p_vld      <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_p_data <= w_rd_data;
                    end
                    r_dout_valid <= r_p_vld;
                    if (r_p_vld) begin
                        r_dout <= r_p_data;
                    end
                end
            end
        end
    endgenerate

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = w_busy;
    assign err        = r_err;

endmodule
